// File: rtl/mpu_multi_mode.sv
// Message processing unit: buffers vertex-update messages, reads the target vertex,
// reduces it (MIN / MAX / saturating SUM), writes it back and forwards activations to the MGU.
module mpu_multi_mode #(
  parameter int VPropWidth   = 32,
  parameter int VPropStart   = 64,
  parameter int EIndexWidth  = 32,
  parameter int EDegreeWidth = 32,
  parameter int AddrWidth    = 33,
  parameter int DataWidth    = 256,
  parameter int UpdateWidth  = AddrWidth + VPropWidth,
  parameter int FifoDepth    = 4,
  parameter int CntWidth     = 32
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic [UpdateWidth-1:0]                      update,
  input  logic                                        update_valid,
  output logic                                        update_ready,
  input  logic [1:0]                                  control,
  output logic [AddrWidth-1:0]                        read_addr,
  input  logic [DataWidth-1:0]                        read_data,
  output logic                                        start_rd,
  input  logic                                        end_rd,
  output logic [AddrWidth-1:0]                        write_addr,
  output logic [DataWidth-1:0]                        write_data,
  output logic                                        start_wr,
  input  logic                                        end_wr,
  output logic [VPropWidth+EIndexWidth+EDegreeWidth-1:0] MGU_data,
  output logic                                        MGU_ready,
  input  logic                                        MGU_resp,
  output logic [CntWidth-1:0]                         upd_count,
  output logic [CntWidth-1:0]                         act_count,
  output logic                                        busy
);

  localparam int PtrWidth  = $clog2(FifoDepth);
  localparam int TempStart = VPropStart + VPropWidth;
  localparam logic [PtrWidth:0]   PtrOne  = {{PtrWidth{1'b0}}, 1'b1};
  localparam logic [PtrWidth:0]   CntFull = (PtrWidth+1)'(FifoDepth);
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [1:0] MODE_MAX = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_SUM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ       = 3'd1,
    S_READ_WAIT  = 3'd2,
    S_REDUCE     = 3'd3,
    S_WRITE      = 3'd4,
    S_WRITE_WAIT = 3'd5,
    S_SEND       = 3'd6
  } state_t;

  function automatic logic [VPropWidth-1:0] sat_add(input logic [VPropWidth-1:0] a,
                                                    input logic [VPropWidth-1:0] b);
    logic [VPropWidth:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[VPropWidth]) sat_add = '1;
    else                 sat_add = sum[VPropWidth-1:0];
  endfunction

  logic [UpdateWidth-1:0] fifo_mem_r [FifoDepth];
  logic [PtrWidth:0]      wr_ptr_r, rd_ptr_r;
  logic [PtrWidth:0]      fifo_cnt_s, fifo_cnt_next_s;
  logic                   push_s, pop_s;
  logic [UpdateWidth-1:0] head_s;

  state_t                 state_r;
  logic [AddrWidth-1:0]   msg_addr_r;
  logic [VPropWidth-1:0]  msg_val_r;
  logic [1:0]             mode_r;
  logic [DataWidth-1:0]   word_r;

  logic                   hit_s;
  logic [DataWidth-1:0]   new_word_s;
  logic [VPropWidth-1:0]  old_temp_s;
  logic [EDegreeWidth-1:0] degree_s;

  assign fifo_cnt_s      = wr_ptr_r - rd_ptr_r;
  assign push_s          = update_valid && update_ready;
  assign pop_s           = (state_r == S_IDLE) && (fifo_cnt_s != '0);
  assign fifo_cnt_next_s = fifo_cnt_s + (push_s ? PtrOne : '0) - (pop_s ? PtrOne : '0);
  assign head_s          = fifo_mem_r[rd_ptr_r[PtrWidth-1:0]];
  assign old_temp_s      = word_r[TempStart +: VPropWidth];
  assign degree_s        = word_r[EDegreeWidth-1:0];
  assign busy            = (fifo_cnt_s != '0) || (state_r != S_IDLE) || MGU_ready;

  // Message FIFO; update_ready is registered so it reads low throughout reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      update_ready <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) fifo_mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[PtrWidth-1:0]] <= update;
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PtrOne;
      update_ready <= (fifo_cnt_next_s != CntFull);
    end
  end

  // Reduction of the captured vertex word against the latched message.
  always_comb begin
    hit_s      = 1'b0;
    new_word_s = word_r;
    case (mode_r)
      MODE_MAX, MODE_MIN: begin
        if ((degree_s != '0) &&
            ((mode_r == MODE_MAX) ? (msg_val_r > old_temp_s) : (msg_val_r < old_temp_s))) begin
          hit_s = 1'b1;
          new_word_s[VPropStart +: VPropWidth] = msg_val_r;
          new_word_s[TempStart +: VPropWidth]  = msg_val_r;
        end else begin
          hit_s = 1'b0;
        end
      end
      MODE_SUM: begin
        hit_s = (msg_val_r != '0);
        new_word_s[TempStart +: VPropWidth] = sat_add(old_temp_s, msg_val_r);
      end
      default: hit_s = 1'b0;
    endcase
  end

  // Processing FSM with registered memory requests, MGU slot and statistics.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      msg_addr_r <= '0;
      msg_val_r  <= '0;
      mode_r     <= 2'b00;
      word_r     <= '0;
      read_addr  <= '0;
      start_rd   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      start_wr   <= 1'b0;
      MGU_data   <= '0;
      MGU_ready  <= 1'b0;
      upd_count  <= '0;
      act_count  <= '0;
    end else begin
      start_rd <= 1'b0;
      start_wr <= 1'b0;
      // SEND only loads an empty slot, so this release never collides with a load.
      if (MGU_ready && MGU_resp) MGU_ready <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            msg_addr_r <= head_s[UpdateWidth-1:VPropWidth];
            msg_val_r  <= head_s[VPropWidth-1:0];
            mode_r     <= control;
            state_r    <= S_READ;
          end
        end
        S_READ: begin
          read_addr <= msg_addr_r;
          start_rd  <= 1'b1;
          state_r   <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (end_rd) begin
            word_r  <= read_data;
            state_r <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          upd_count <= upd_count + CntOne;
          word_r    <= new_word_s;
          state_r   <= hit_s ? S_WRITE : S_IDLE;
        end
        S_WRITE: begin
          write_addr <= msg_addr_r;
          write_data <= word_r;
          start_wr   <= 1'b1;
          state_r    <= S_WRITE_WAIT;
        end
        S_WRITE_WAIT: begin
          if (end_wr) begin
            state_r <= ((mode_r == MODE_MIN) || (mode_r == MODE_MAX)) ? S_SEND : S_IDLE;
          end
        end
        S_SEND: begin
          if (!MGU_ready) begin
            MGU_data  <= {word_r[VPropStart +: VPropWidth],
                          word_r[EDegreeWidth +: EIndexWidth],
                          word_r[EDegreeWidth-1:0]};
            MGU_ready <= 1'b1;
            act_count <= act_count + CntOne;
            state_r   <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_multi_mode.sv
// Directed self-checking bench for mpu_multi_mode with a hand-driven HBM and MGU.
module tb_mpu_multi_mode;

  localparam logic [127:0] UPPER = 128'hC3C3_5A5A_0F0F_9696_1234_5678_9ABC_DEF0;

  logic         clk = 1'b0;
  logic         resetn;
  logic [64:0]  update;
  logic         update_valid;
  logic         update_ready;
  logic [1:0]   control;
  logic [32:0]  read_addr;
  logic [255:0] read_data;
  logic         start_rd;
  logic         end_rd;
  logic [32:0]  write_addr;
  logic [255:0] write_data;
  logic         start_wr;
  logic         end_wr;
  logic [95:0]  MGU_data;
  logic         MGU_ready;
  logic         MGU_resp;
  logic [31:0]  upd_count;
  logic [31:0]  act_count;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_req_cnt = 0;
  int wr_req_cnt = 0;
  int rd_served = 0;
  int wr_served = 0;
  logic [32:0]  cap_rd_addr;
  logic [32:0]  cap_wr_addr;
  logic [255:0] cap_wr_data;

  mpu_multi_mode dut (
    .clk(clk), .resetn(resetn),
    .update(update), .update_valid(update_valid), .update_ready(update_ready),
    .control(control),
    .read_addr(read_addr), .read_data(read_data), .start_rd(start_rd), .end_rd(end_rd),
    .write_addr(write_addr), .write_data(write_data), .start_wr(start_wr), .end_wr(end_wr),
    .MGU_data(MGU_data), .MGU_ready(MGU_ready), .MGU_resp(MGU_resp),
    .upd_count(upd_count), .act_count(act_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record memory requests so one-cycle pulses are never missed.
  always @(posedge clk) begin
    if (start_rd) begin
      rd_req_cnt  <= rd_req_cnt + 1;
      cap_rd_addr <= read_addr;
    end
    if (start_wr) begin
      wr_req_cnt  <= wr_req_cnt + 1;
      cap_wr_addr <= write_addr;
      cap_wr_data <= write_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [255:0] make_vtx(input logic [31:0] t, input logic [31:0] p,
                                            input logic [31:0] idx, input logic [31:0] deg);
    make_vtx = {UPPER, t, p, idx, deg};
  endfunction

  function automatic logic [32:0] bp_addr(input int i);
    bp_addr = 33'h2000 + 33'(i * 64);
  endfunction

  function automatic logic [95:0] bp_mgu(input int i);
    bp_mgu = {32'd200 + 32'(i), 32'h100 + 32'(i), 32'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg(input logic [32:0] a, input logic [31:0] v);
    for (int k = 0; k < 100 && !update_ready; k++) tick();
    check("push_ready", 256'(update_ready), 256'(1'b1));
    update       = {a, v};
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic serve_read(input logic [32:0] exp_addr, input logic [255:0] data);
    for (int k = 0; k < 100 && rd_req_cnt <= rd_served; k++) tick();
    check("rd_req", 256'(rd_req_cnt > rd_served), 256'(1'b1));
    check("rd_addr", 256'(cap_rd_addr), 256'(exp_addr));
    read_data = data;
    end_rd    = 1'b1;
    tick();
    end_rd    = 1'b0;
    rd_served++;
  endtask

  task automatic serve_write(input logic [32:0] exp_addr, input logic [255:0] exp_data);
    for (int k = 0; k < 100 && wr_req_cnt <= wr_served; k++) tick();
    check("wr_req", 256'(wr_req_cnt > wr_served), 256'(1'b1));
    check("wr_addr", 256'(cap_wr_addr), 256'(exp_addr));
    check("wr_data", cap_wr_data, exp_data);
    end_wr = 1'b1;
    tick();
    end_wr = 1'b0;
    wr_served++;
  endtask

  initial begin
    resetn = 1'b0; update = '0; update_valid = 1'b0; control = 2'b00;
    read_data = '0; end_rd = 1'b0; end_wr = 1'b0; MGU_resp = 1'b0;
    repeat (3) tick();
    check("rst_ready", 256'(update_ready), 256'(1'b0));
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_mgu", 256'(MGU_ready), 256'(1'b0));
    check("rst_upd", 256'(upd_count), 256'(32'd0));
    resetn = 1'b1;
    check("ready_pre", 256'(update_ready), 256'(1'b0));
    tick();
    check("ready_post", 256'(update_ready), 256'(1'b1));

    // MIN hit with exact request latencies
    control = 2'b10;
    push_msg(33'h1000, 32'd4);
    check("rd_lat0", 256'(start_rd), 256'(1'b0));
    tick();
    check("rd_lat1", 256'(start_rd), 256'(1'b0));
    tick();
    check("rd_lat2", 256'(start_rd), 256'(1'b1));
    serve_read(33'h1000, make_vtx(32'd10, 32'd10, 32'h40, 32'd3));
    tick();
    check("wr_lat0", 256'(start_wr), 256'(1'b0));
    tick();
    check("wr_lat1", 256'(start_wr), 256'(1'b1));
    serve_write(33'h1000, make_vtx(32'd4, 32'd4, 32'h40, 32'd3));
    check("min_mgu_pre", 256'(MGU_ready), 256'(1'b0));
    tick();
    check("min_mgu_rdy", 256'(MGU_ready), 256'(1'b1));
    check("min_mgu_data", 256'(MGU_data), 256'({32'd4, 32'h40, 32'd3}));
    check("min_act", 256'(act_count), 256'(32'd1));
    check("min_upd", 256'(upd_count), 256'(32'd1));
    MGU_resp = 1'b1;
    tick();
    MGU_resp = 1'b0;
    check("min_mgu_clr", 256'(MGU_ready), 256'(1'b0));
    check("min_idle", 256'(busy), 256'(1'b0));

    // MIN miss, then MIN with zero degree
    push_msg(33'h1040, 32'd12);
    serve_read(33'h1040, make_vtx(32'd10, 32'd10, 32'h41, 32'd3));
    tick();
    check("miss_idle", 256'(busy), 256'(1'b0));
    push_msg(33'h1080, 32'd1);
    serve_read(33'h1080, make_vtx(32'd10, 32'd10, 32'h42, 32'd0));
    tick();
    check("deg0_idle", 256'(busy), 256'(1'b0));
    check("miss_nowr", 256'(wr_req_cnt), 256'(wr_served));
    check("miss_nomgu", 256'(MGU_ready), 256'(1'b0));
    check("miss_upd", 256'(upd_count), 256'(32'd3));

    // SUM: saturating, non-saturating with zero degree, and zero value
    control = 2'b11;
    push_msg(33'h1100, 32'h20);
    serve_read(33'h1100, make_vtx(32'hFFFF_FFF0, 32'h55, 32'd7, 32'd2));
    serve_write(33'h1100, make_vtx(32'hFFFF_FFFF, 32'h55, 32'd7, 32'd2));
    check("sum_idle", 256'(busy), 256'(1'b0));
    tick();
    check("sum_nomgu", 256'(MGU_ready), 256'(1'b0));
    check("sum_act", 256'(act_count), 256'(32'd1));
    push_msg(33'h1140, 32'd5);
    serve_read(33'h1140, make_vtx(32'd100, 32'd9, 32'd8, 32'd0));
    serve_write(33'h1140, make_vtx(32'd105, 32'd9, 32'd8, 32'd0));
    push_msg(33'h1180, 32'd0);
    serve_read(33'h1180, make_vtx(32'd100, 32'd9, 32'd8, 32'd2));
    tick();
    check("sum0_idle", 256'(busy), 256'(1'b0));
    check("sum0_nowr", 256'(wr_req_cnt), 256'(wr_served));

    // pass mode never writes
    control = 2'b00;
    push_msg(33'h11C0, 32'd5);
    serve_read(33'h11C0, make_vtx(32'd10, 32'd10, 32'd1, 32'd3));
    tick();
    check("pass_nowr", 256'(wr_req_cnt), 256'(wr_served));
    check("pass_upd", 256'(upd_count), 256'(32'd7));

    // MAX backpressure: stalled read fills the FIFO, then the MGU slot parks the FSM
    control = 2'b01;
    for (int i = 0; i < 5; i++) push_msg(bp_addr(i), 32'd200 + 32'(i));
    check("full_ready", 256'(update_ready), 256'(1'b0));
    repeat (3) tick();
    check("full_hold", 256'(update_ready), 256'(1'b0));
    check("full_one_rd", 256'(rd_req_cnt), 256'(rd_served + 1));
    for (int i = 0; i < 6; i++) begin
      if (i == 1) push_msg(bp_addr(5), 32'd205);
      serve_read(bp_addr(i), make_vtx(32'd100, 32'd100, 32'h100 + 32'(i), 32'd1));
      serve_write(bp_addr(i), make_vtx(32'd200 + 32'(i), 32'd200 + 32'(i), 32'h100 + 32'(i), 32'd1));
      if (i > 0) begin
        repeat (2) tick();
        check("bp_park_rd", 256'(rd_req_cnt), 256'(rd_served));
        check("bp_hold_rdy", 256'(MGU_ready), 256'(1'b1));
        check("bp_hold_data", 256'(MGU_data), 256'(bp_mgu(i - 1)));
        MGU_resp = 1'b1;
        tick();
        MGU_resp = 1'b0;
        check("bp_clr", 256'(MGU_ready), 256'(1'b0));
      end
      tick();
      check("bp_rdy", 256'(MGU_ready), 256'(1'b1));
      check("bp_data", 256'(MGU_data), 256'(bp_mgu(i)));
    end
    MGU_resp = 1'b1;
    tick();
    MGU_resp = 1'b0;
    check("bp_final_clr", 256'(MGU_ready), 256'(1'b0));
    check("bp_act", 256'(act_count), 256'(32'd7));
    check("bp_upd", 256'(upd_count), 256'(32'd13));
    check("bp_idle", 256'(busy), 256'(1'b0));

    // asynchronous reset while waiting for end_wr
    control = 2'b10;
    push_msg(33'h3000, 32'd5);
    serve_read(33'h3000, make_vtx(32'd10, 32'd10, 32'h50, 32'd3));
    for (int k = 0; k < 100 && wr_req_cnt <= wr_served; k++) tick();
    check("arst_wr_req", 256'(wr_req_cnt > wr_served), 256'(1'b1));
    check("arst_pre_waddr", 256'(write_addr), 256'(33'h3000));
    #3 resetn = 1'b0;
    #1;
    check("arst_waddr", 256'(write_addr), 256'(33'h0));
    check("arst_wdata", write_data, 256'(1'b0));
    check("arst_raddr", 256'(read_addr), 256'(33'h0));
    check("arst_upd", 256'(upd_count), 256'(32'd0));
    check("arst_act", 256'(act_count), 256'(32'd0));
    check("arst_ready", 256'(update_ready), 256'(1'b0));
    check("arst_busy", 256'(busy), 256'(1'b0));
    @(posedge clk);
    #1 resetn = 1'b1;
    wr_served = wr_req_cnt;
    tick();
    check("arst_ready_up", 256'(update_ready), 256'(1'b1));
    end_wr = 1'b1;
    tick();
    end_wr = 1'b0;
    tick();
    check("late_wr_mgu", 256'(MGU_ready), 256'(1'b0));
    check("late_wr_busy", 256'(busy), 256'(1'b0));
    push_msg(33'h3040, 32'd7);
    serve_read(33'h3040, make_vtx(32'd10, 32'd10, 32'h51, 32'd3));
    serve_write(33'h3040, make_vtx(32'd7, 32'd7, 32'h51, 32'd3));
    tick();
    check("post_rst_rdy", 256'(MGU_ready), 256'(1'b1));
    check("post_rst_data", 256'(MGU_data), 256'({32'd7, 32'h51, 32'd3}));
    check("post_rst_act", 256'(act_count), 256'(32'd1));
    check("post_rst_upd", 256'(upd_count), 256'(32'd1));
    MGU_resp = 1'b1;
    tick();
    MGU_resp = 1'b0;
    check("post_rst_clr", 256'(MGU_ready), 256'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpu_multi_mode.md
# mpu_multi_mode

Parametrised message processing unit for the graph pipeline. It buffers incoming vertex-update messages in a small FIFO, reads the target vertex from HBM, and reduces it in one of three modes (MIN, MAX, saturating SUM). It writes changed vertices back and forwards activated vertices to the MGU through a held one-entry output slot, so the next message can start while the MGU is still acknowledging.

## Interface
- VPropWidth, 32, vertex property width
- VPropStart, 64, bit position of prop in vertex word; temp prop sits directly above it
- EIndexWidth, 32, edge base index width, located at [EIndexWidth+EDegreeWidth-1:EDegreeWidth]
- EDegreeWidth, 32, edge degree width, located at [EDegreeWidth-1:0]
- AddrWidth, 33, HBM byte address width
- DataWidth, 256, HBM word width
- UpdateWidth, AddrWidth+VPropWidth, message = {addr, value}
- FifoDepth, 4, message FIFO depth, power of two ≥ 2
- CntWidth, 32, statistics counter width

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- update  in  UpdateWidth  message
- update_valid  in  1  message offered
- update_ready  out  1  FIFO not full
- control  in  2  mode: 00 pass, 01 MAX, 10 MIN, 11 SUM
- read_addr  out  AddrWidth  vertex read address
- read_data  in  DataWidth  vertex read data
- start_rd  out  1  one-cycle read request
- end_rd  in  1  read data valid
- write_addr  out  AddrWidth  vertex write address
- write_data  out  DataWidth  updated vertex
- start_wr  out  1  one-cycle write request
- end_wr  in  1  write done
- MGU_data  out  VPropWidth+EIndexWidth+EDegreeWidth  {result, edge_index, edge_degree}
- MGU_ready  out  1  MGU slot full
- MGU_resp  in  1  MGU accepted slot
- upd_count  out  CntWidth  messages processed
- act_count  out  CntWidth  messages sent to MGU
- busy  out  1  FIFO non-empty, FSM not IDLE, or MGU_ready high

## Operation
- Push on update_valid & update_ready. update_ready = !full, independent of same-cycle pop.
- States: IDLE, READ, READ_WAIT, REDUCE, WRITE, WRITE_WAIT, SEND.
- IDLE: if FIFO non-empty, pop, latch message and control → READ.
- READ: start_rd=1, read_addr=message addr → READ_WAIT.
- READ_WAIT: on end_rd, capture read_data → REDUCE. end_rd is ignored in all other states.
- REDUCE: let t=old temp prop, p=old prop, d=degree, v=new value.
  - MIN: hit = (v<t) && d≠0; on hit, prop=temp=v.
  - MAX: hit = (v>t) && d≠0; on hit, prop=temp=v.
  - SUM: hit = v≠0; temp = min(t+v, all-ones) (unsigned saturate); prop unchanged; never sends to MGU.
  - pass: hit=0.
  - upd_count++ always. No hit → IDLE. Hit → WRITE.
- WRITE: start_wr=1. write_addr = read address. write_data = read word with only the prop/temp fields replaced → WRITE_WAIT.
- WRITE_WAIT: on end_wr, go to SEND if mode is MIN/MAX, else IDLE.
- SEND: wait while MGU_ready=1. When the slot is free, load MGU_data={prop, edge_index, edge_degree}, set MGU_ready, act_count++ → IDLE.
- MGU slot: MGU_ready and MGU_data hold until MGU_resp is sampled high; then MGU_ready clears next cycle. MGU_resp while MGU_ready=0 is ignored.
- Counters wrap modulo 2^CntWidth.

## Timing
- Reset (async assert, deasserts synchronous to clk): all outputs 0, FIFO emptied, state IDLE. update_ready rises 1 cycle after deassert. An in-flight HBM transaction is abandoned; late end_rd/end_wr are ignored.
- Pop occurs in the cycle after push when the FIFO is empty and the FSM is IDLE. start_rd is high 2 cycles after the accepting edge.
- No-hit message: IDLE back to IDLE in 4 cycles plus read wait.
- Hit, MGU free: MGU_ready rises 2 cycles after the end_rd-sampling edge plus 2 cycles plus write wait.
- Memory requests are single-outstanding; there is no RAW hazard.
- Messages are processed and forwarded strictly in FIFO order.

## Test plan
- MIN hit: vertex t=10, p=10, d=3, idx=0x40; message v=4. Expect write prop=temp=4 with other bits identical, MGU_data={4,0x40,3}, act_count=1.
- MIN miss and zero degree: v=12 with t=10, then v=1 with d=0. Expect no start_wr, no MGU_ready, upd_count=2.
- SUM saturation: t=0xFFFFFFF0, v=0x20. Expect temp=0xFFFFFFFF, prop unchanged, MGU_ready stays 0.
- Backpressure: hold MGU_resp=0, send 6 MAX-hit messages. Expect update_ready low after FIFO and pipeline fill, FSM parked in SEND, in-order MGU_data as MGU_resp is pulsed.
- FIFO full: FifoDepth=4, stall end_rd, push 5 messages. Expect 5th accepted only after first pop; no loss or duplication.
- Async reset mid-WRITE_WAIT: assert resetn=0 off-edge. Expect outputs 0 immediately; a later end_wr is ignored; the next message processes normally.
